// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and helpers.
// Used by the fetch path and the FIFO-based memory paths.
package rv32i_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSTR =
    32'h0000_0013;

  localparam logic [XLEN-1:0] ALIGN_MASK =
    ~XLEN'(INSTR_BYTES - 1);

  localparam logic [XLEN-1:0] PC_STEP =
    XLEN'(INSTR_BYTES);

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return a & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head word is read combinationally.
// Ports: push/pop/flush controls, push data, head data, occupancy.
module sync_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = XLEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetcher: runs sequential fetches ahead of the core PC.
// Ports: core PC/ready in, instr/valid out; mem req/rsp; fifo_count.
module instr_prefetch_buffer
  import rv32i_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [XLEN-1:0]            cpu_pc,
  input  logic                       cpu_instr_ready,
  output logic [XLEN-1:0]            cpu_instr_code,
  output logic                       cpu_instr_valid,
  output logic                       mem_req_valid,
  output logic [XLEN-1:0]            mem_req_addr,
  input  logic                       mem_req_ready,
  input  logic                       mem_rsp_valid,
  input  logic [XLEN-1:0]            mem_rsp_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [CW-1:0]   live_q, live_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count;
  logic [CW:0]     occ_sum;
  logic [CW:0]     infl_sum;
  logic [XLEN-1:0] pc_al;
  logic [XLEN-1:0] head_word;
  logic            redirect;
  logic            accept;
  logic            rsp_drop;
  logic            push;
  logic            pop;

  assign pc_al    = word_align(cpu_pc);
  assign redirect = (pc_al != head_pc_q);

  // FIFO room and in-flight tags are both bounded by DEPTH.
  assign occ_sum  = {1'b0, count}  + {1'b0, live_q};
  assign infl_sum = {1'b0, live_q} + {1'b0, drop_q};

  assign mem_req_valid = !rst && !redirect &&
                         (occ_sum < DEPTH_W) &&
                         (infl_sum < DEPTH_W);
  assign mem_req_addr  = fetch_addr_q;
  assign accept        = mem_req_valid && mem_req_ready;

  // Stale responses, and any response racing a redirect, are dropped.
  assign rsp_drop = mem_rsp_valid &&
                    ((drop_q != '0) || redirect);
  assign push     = mem_rsp_valid && !rsp_drop;

  assign cpu_instr_valid = !rst && !redirect &&
                           (count != '0);
  assign pop             = cpu_instr_valid && cpu_instr_ready;
  assign cpu_instr_code  = cpu_instr_valid ? head_word
                                           : NOP_INSTR;
  assign fifo_count      = count;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    head_pc_d    = head_pc_q;
    live_d       = live_q;
    drop_d       = drop_q;
    unique case (1'b1)
      redirect: begin
        fetch_addr_d = pc_al;
        head_pc_d    = pc_al;
        live_d       = '0;
        drop_d       = drop_q + live_q
                     - CW'(mem_rsp_valid);
      end
      default: begin
        if (accept) begin
          fetch_addr_d = fetch_addr_q + PC_STEP;
        end
        if (pop) begin
          head_pc_d = head_pc_q + PC_STEP;
        end
        live_d = live_q + CW'(accept) - CW'(push);
        if (mem_rsp_valid && (drop_q != '0)) begin
          drop_d = drop_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr_q <= RESET_PC;
      head_pc_q    <= RESET_PC;
      live_q       <= '0;
      drop_q       <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
      live_q       <= live_d;
      drop_q       <= drop_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (mem_rsp_data),
    .pop_i       (pop),
    .flush_i     (redirect),
    .head_o      (head_word),
    .count_o     (count)
  );

  // Memory must not answer more than was asked, nor overfill the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_no_ovf: assert (!(push &&
                          count == CW'(DEPTH)));
      a_rsp_owed: assert (!(mem_rsp_valid &&
                            infl_sum == '0));
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer with a latency memory model.
// A second instance (no responses) checks the wrapping fetch sequence.
module tb_instr_prefetch_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_pc = '0;
  logic        cpu_instr_ready = 1'b1;
  logic [31:0] cpu_instr_code;
  logic        cpu_instr_valid;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic [2:0]  fifo_count;

  logic [31:0] w_pc = 32'hFFFF_FFF8;
  logic        w_ready = 1'b1;
  logic [31:0] w_code;
  logic        w_valid;
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_req_ready = 1'b1;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic [2:0]  w_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          delivered = 0;
  bit          auto_step = 1'b1;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] req_log   [$];
  logic [31:0] wlog      [$];
  logic [31:0] wexp [4] = '{32'hFFFF_FFF8,
                            32'hFFFF_FFFC,
                            32'h0000_0000,
                            32'h0000_0004};

  always #5 clk = ~clk;

  instr_prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_pc          (cpu_pc),
    .cpu_instr_ready (cpu_instr_ready),
    .cpu_instr_code  (cpu_instr_code),
    .cpu_instr_valid (cpu_instr_valid),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .fifo_count      (fifo_count)
  );

  instr_prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_w (
    .clk             (clk),
    .rst             (rst),
    .cpu_pc          (w_pc),
    .cpu_instr_ready (w_ready),
    .cpu_instr_code  (w_code),
    .cpu_instr_valid (w_valid),
    .mem_req_valid   (w_req_valid),
    .mem_req_addr    (w_req_addr),
    .mem_req_ready   (w_req_ready),
    .mem_rsp_valid   (w_rsp_valid),
    .mem_rsp_data    (w_rsp_data),
    .fifo_count      (w_count)
  );

  // One clock: sample mid-cycle, then update memory and core model.
  task automatic tick();
    logic        hs, hsw, pop_s, rst_s;
    logic [31:0] a, aw;
    @(negedge clk);
    rst_s = rst;
    hs    = mem_req_valid && mem_req_ready;
    a     = mem_req_addr;
    hsw   = w_req_valid && w_req_ready;
    aw    = w_req_addr;
    pop_s = cpu_instr_valid && cpu_instr_ready;
    if (pop_s) delivered++;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_s) begin
      pend_addr.delete();
      pend_due.delete();
      req_log.delete();
      wlog.delete();
    end else begin
      if (hs) begin
        pend_addr.push_back(a);
        pend_due.push_back(cyc - 1 + lat);
        req_log.push_back(a);
      end
      if (hsw) wlog.push_back(aw);
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = pend_addr.pop_front();
      void'(pend_due.pop_front());
    end
    if (auto_step && pop_s) cpu_pc = cpu_pc + 32'd4;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_pc = '0;
    cpu_instr_ready = 1'b1;
    mem_req_ready = 1'b1;
    auto_step = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_pc = '0;
    tick();
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_req_valid got=%b exp=0",
               mem_req_valid);
    end
    n_cmp++;
    if (cpu_instr_code !== NOP) begin
      n_bad++;
      $display("FAIL rst_code got=%h exp=%h",
               cpu_instr_code, NOP);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL rel_count got=%0d exp=0",
               fifo_count);
    end
    n_cmp++;
    if (cpu_instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rel_valid got=%b exp=0",
               cpu_instr_valid);
    end
    n_cmp++;
    if (mem_req_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rel_req_valid got=%b exp=1",
               mem_req_valid);
    end
    n_cmp++;
    if (mem_req_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL rel_req_addr got=%h exp=0",
               mem_req_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1;
    tick();
    n_cmp++;
    if (cpu_instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL str_c1_valid got=%b exp=0",
               cpu_instr_valid);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cpu_instr_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL str_valid[%0d] got=%b exp=1",
                 i, cpu_instr_valid);
      end
      n_cmp++;
      if (cpu_instr_code !== 32'(4*i)) begin
        n_bad++;
        $display("FAIL str_code[%0d] got=%h exp=%h",
                 i, cpu_instr_code, 32'(4*i));
      end
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (req_log[j] !== 32'(4*j)) begin
        n_bad++;
        $display("FAIL str_req[%0d] got=%h exp=%h",
                 j, req_log[j], 32'(4*j));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat = 2;
    mem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (mem_req_valid !== 1'b1 ||
          mem_req_addr !== 32'h0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d] got=%b/%h exp=1/0",
                 i, mem_req_valid, mem_req_addr);
      end
      tick();
    end
    mem_req_ready = 1'b1;
    delivered = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (fifo_count > 3'd4) begin
        n_bad++;
        $display("FAIL stall_count[%0d] got=%0d exp<=4",
                 i, fifo_count);
      end
      n_cmp++;
      if (pend_addr.size() > 4) begin
        n_bad++;
        $display("FAIL stall_infl[%0d] got=%0d exp<=4",
                 i, pend_addr.size());
      end
      if (cpu_instr_valid) begin
        n_cmp++;
        if (cpu_instr_code !== cpu_pc) begin
          n_bad++;
          $display("FAIL stall_code[%0d] got=%h exp=%h",
                   i, cpu_instr_code, cpu_pc);
        end
      end
      tick();
    end
    n_cmp++;
    if (delivered != 17) begin
      n_bad++;
      $display("FAIL stall_delivered got=%0d exp=17",
               delivered);
    end
  endtask

  task automatic test_redirect();
    bit found;
    do_reset();
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cpu_instr_valid && cpu_pc == 32'h10) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_bad++;
      $display("FAIL redir_reach got=%b exp=1", found);
    end
    tick();
    cpu_pc = 32'h200;
    #1;
    n_cmp++;
    if (cpu_instr_valid !== 1'b0 ||
        cpu_instr_code !== NOP) begin
      n_bad++;
      $display("FAIL redir_cycle got=%b/%h exp=0/%h",
               cpu_instr_valid, cpu_instr_code, NOP);
    end
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_noreq got=%b exp=0",
               mem_req_valid);
    end
    tick();
    n_cmp++;
    if (mem_req_valid !== 1'b1 ||
        mem_req_addr !== 32'h200) begin
      n_bad++;
      $display("FAIL redir_refetch got=%b/%h exp=1/200",
               mem_req_valid, mem_req_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (cpu_instr_valid) begin
        found = 1'b1;
        break;
      end
      n_cmp++;
      if (cpu_instr_code !== NOP) begin
        n_bad++;
        $display("FAIL redir_gap[%0d] got=%h exp=%h",
                 i, cpu_instr_code, NOP);
      end
      tick();
    end
    n_cmp++;
    if (found !== 1'b1 ||
        cpu_instr_code !== 32'h200) begin
      n_bad++;
      $display("FAIL redir_first got=%b/%h exp=1/200",
               found, cpu_instr_code);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pc_s;
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) tick();
    cpu_instr_ready = 1'b0;
    #1;
    pc_s = cpu_pc;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (fifo_count !== 3'd4) begin
      n_bad++;
      $display("FAIL bp_full got=%0d exp=4", fifo_count);
    end
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_noreq got=%b exp=0",
               mem_req_valid);
    end
    n_cmp++;
    if (cpu_instr_code !== pc_s) begin
      n_bad++;
      $display("FAIL bp_hold got=%h exp=%h",
               cpu_instr_code, pc_s);
    end
    tick();
    cpu_instr_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (cpu_instr_valid !== 1'b1 ||
          cpu_instr_code !== pc_s + 32'(4*i)) begin
        n_bad++;
        $display("FAIL bp_drain[%0d] got=%b/%h exp=1/%h",
                 i, cpu_instr_valid, cpu_instr_code,
                 pc_s + 32'(4*i));
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] got;
    bit          found;
    do_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (wlog.size() != 4) begin
      n_bad++;
      $display("FAIL wrap_nreq got=%0d exp=4",
               wlog.size());
    end
    for (int j = 0; j < 4; j++) begin
      got = (j < wlog.size()) ? wlog[j]
                              : 32'hDEAD_BEEF;
      n_cmp++;
      if (got !== wexp[j]) begin
        n_bad++;
        $display("FAIL wrap_req[%0d] got=%h exp=%h",
                 j, got, wexp[j]);
      end
    end
    n_cmp++;
    if (w_req_valid !== 1'b0 || w_valid !== 1'b0 ||
        w_count !== 3'd0 || w_code !== NOP) begin
      n_bad++;
      $display("FAIL wrap_idle got=%b/%b/%0d/%h exp=0/0/0/%h",
               w_req_valid, w_valid, w_count, w_code, NOP);
    end
    cpu_pc = 32'hFFFF_FFF8;
    #1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_instr_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_reach got=%b exp=1", found);
    end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (cpu_instr_valid !== 1'b1 ||
          cpu_instr_code !== wexp[j]) begin
        n_bad++;
        $display("FAIL wrap_code[%0d] got=%b/%h exp=1/%h",
                 j, cpu_instr_valid, cpu_instr_code,
                 wexp[j]);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) tick();
    cpu_instr_ready = 1'b0;
    #1;
    tick();
    n_cmp++;
    if (fifo_count !== 3'd2) begin
      n_bad++;
      $display("FAIL mrst_pre got=%0d exp=2", fifo_count);
    end
    rst = 1'b1;
    cpu_pc = '0;
    cpu_instr_ready = 1'b1;
    tick();
    n_cmp++;
    if (fifo_count !== 3'd0 ||
        cpu_instr_valid !== 1'b0 ||
        cpu_instr_code !== NOP) begin
      n_bad++;
      $display("FAIL mrst_clr got=%0d/%b/%h exp=0/0/%h",
               fifo_count, cpu_instr_valid,
               cpu_instr_code, NOP);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_req_valid !== 1'b1 ||
        mem_req_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL mrst_refetch got=%b/%h exp=1/0",
               mem_req_valid, mem_req_addr);
    end
    tick();
    tick();
    n_cmp++;
    if (cpu_instr_valid !== 1'b1 ||
        cpu_instr_code !== 32'h0) begin
      n_bad++;
      $display("FAIL mrst_first got=%b/%h exp=1/0",
               cpu_instr_valid, cpu_instr_code);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
